// File: rtl/pe_psum_drain.sv
`default_nettype none
// ============================================================================
//  Module   : pe_psum_drain
//  Purpose  : Drains partial sums out of a PE shift chain, requantizes each
//             one (round, arithmetic shift, saturate) and hands the results
//             downstream through a small valid/ready output FIFO.
//  Options  : define PSUM_DRAIN_RELU_EN to clamp negative results to zero
//             (output range becomes [0, 2^(DATA_WIDTH-1)-1]).
//  Revision : 1.0 - initial release
// ============================================================================
module pe_psum_drain #(
  parameter int PSUM_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter int CHAIN_LEN  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  sel_bank,
  input  logic [4:0]            shift_amt,
  input  logic [PSUM_WIDTH-1:0] chain_in,
  output logic                  shift_out,
  output logic                  sel_pe_reg_out,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int EXT_W = PSUM_WIDTH + 1;

  // Saturation bounds expressed in the widened arithmetic domain.
  localparam logic signed [EXT_W-1:0] SAT_MAX =
    {{(EXT_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
`ifdef PSUM_DRAIN_RELU_EN
  localparam logic signed [EXT_W-1:0] SAT_MIN = '0;
`else
  localparam logic signed [EXT_W-1:0] SAT_MIN =
    {{(EXT_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic                     w_start_ok;
  logic                     r_sel_bank;
  logic [4:0]               r_shift_amt;
  logic [CNT_W-1:0]         r_count;

  logic [DATA_WIDTH-1:0]    r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [OCC_W-1:0]         r_occ;
  logic [OCC_W-1:0]         w_occ_next;
  logic                     r_full;
  logic                     r_empty;
  logic                     w_push;
  logic                     w_pop;

  logic signed [EXT_W-1:0]  w_round;
  logic signed [EXT_W-1:0]  w_sum;
  logic signed [EXT_W-1:0]  w_shifted;
  logic [DATA_WIDTH-1:0]    w_quant;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and control outputs; shift_out looks only at the registered
  // full flag so out_ready never reaches the chain combinationally.
  always_comb begin
    w_state_next = r_state;
    w_start_ok   = 1'b0;
    shift_out    = 1'b0;
    done         = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_start_ok   = 1'b1;
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy      = 1'b1;
        shift_out = !r_full;
        if (!r_full && (r_count == CNT_W'(CHAIN_LEN - 1))) w_state_next = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        // Start is not sampled here, so a start coincident with done is dropped.
        if (r_empty) begin
          done         = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Drain configuration latched on an accepted start, plus the capture count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel_bank  <= 1'b0;
      r_shift_amt <= 5'd0;
      r_count     <= '0;
    end else if (w_start_ok) begin
      r_sel_bank  <= sel_bank;
      r_shift_amt <= shift_amt;
      r_count     <= '0;
    end else if (w_push) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Requantization: round half up, arithmetic shift, saturate.
  always_comb begin
    w_round = '0;
    if (r_shift_amt != 5'd0) w_round = EXT_W'(1) << (r_shift_amt - 5'd1);
    w_sum     = $signed({chain_in[PSUM_WIDTH-1], chain_in}) + w_round;
    w_shifted = w_sum >>> r_shift_amt;
    if (w_shifted > SAT_MAX)      w_quant = SAT_MAX[DATA_WIDTH-1:0];
    else if (w_shifted < SAT_MIN) w_quant = SAT_MIN[DATA_WIDTH-1:0];
    else                          w_quant = w_shifted[DATA_WIDTH-1:0];
  end

  assign w_push = shift_out;
  assign w_pop  = !r_empty && out_ready;

  // Occupancy update for simultaneous push/pop.
  always_comb begin
    w_occ_next = r_occ;
    case ({w_push, w_pop})
      2'b10:   w_occ_next = r_occ + OCC_W'(1);
      2'b01:   w_occ_next = r_occ - OCC_W'(1);
      default: w_occ_next = r_occ;
    endcase
  end

  // Output FIFO storage, pointers and registered full/empty flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_quant;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_occ   <= w_occ_next;
      r_full  <= (w_occ_next == OCC_W'(FIFO_DEPTH));
      r_empty <= (w_occ_next == '0);
    end
  end

  assign out_valid      = !r_empty;
  assign out_data       = r_mem[r_rd_ptr];
  assign sel_pe_reg_out = r_sel_bank;

endmodule
`default_nettype wire
